axil_reg_station: RTL and testbench
===================================

# axil_reg_station

Full-throughput AXI4-Lite register slice placed between an AXI-Lite master (slave port `s_`) and a slave (master port `m_`). It breaks every combinational path on all five channels (AW, W, B, AR, R), including valid, ready and payload. It sits directly downstream of the block-level reset conditioning and consumes the conditioned `aresetn`.

## Interface
Parameters:
- `ADDR_W`, default 32, address width of AW/AR.
- `DATA_W`, default 32, data width of W/R; must be 32 or 64; strobe width is `DATA_W/8`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `s_awvalid`/`s_awaddr`/`s_awprot`  in  1/ADDR_W/3  upstream AW; `s_awready` out 1.
- `s_wvalid`/`s_wdata`/`s_wstrb`  in  1/DATA_W/DATA_W/8  upstream W; `s_wready` out 1.
- `s_bvalid`/`s_bresp`  out  1/2  upstream B; `s_bready` in 1.
- `s_arvalid`/`s_araddr`/`s_arprot`  in  1/ADDR_W/3  upstream AR; `s_arready` out 1.
- `s_rvalid`/`s_rdata`/`s_rresp`  out  1/DATA_W/2  upstream R; `s_rready` in 1.
- `m_awvalid`/`m_awaddr`/`m_awprot`  out, plus `m_awready` in: mirror of the `s_aw` bundle.
- `m_wvalid`/`m_wdata`/`m_wstrb` out, plus `m_wready` in.
- `m_bvalid`/`m_bresp` in, plus `m_bready` out.
- `m_arvalid`/`m_araddr`/`m_arprot` out, plus `m_arready` in.
- `m_rvalid`/`m_rdata`/`m_rresp` in, plus `m_rready` out.

## Operation
- Each channel is one independent 2-entry skid buffer: a main register (drives the output) and a skid register. Forward channels are AW, W and AR. Reverse channels are B and R.
- No cross-channel coupling. AW and W are forwarded independently. B and R are not matched to requests.
- Per-buffer states:
  - EMPTY: out_valid = 0, in_ready = 1.
  - ONE: main valid, in_ready = 1.
  - FULL: main and skid valid, in_ready = 0.
- Let in_fire = in_valid & in_ready and out_fire = out_valid & out_ready. Transitions:
  - EMPTY, in_fire → ONE; main ← input.
  - ONE, in_fire & !out_fire → FULL; skid ← input.
  - ONE, !in_fire & out_fire → EMPTY.
  - ONE, in_fire & out_fire → ONE; main ← input.
  - FULL, out_fire → ONE; main ← skid. in_fire cannot occur in FULL.
  - All other cases hold state.
- in_ready is a flop, loaded with (next_state != FULL).
- out_valid is a flop, equal to (state != EMPTY).
- Payload is never modified: no width changes, no response generation.
- While a buffer is stalled, out_valid and payload stay stable until out_fire, as AXI requires.
- Reset values:
  - All `*valid` outputs 0.
  - All `*ready` outputs 0.
  - All payload outputs 0.
  - All buffers EMPTY.
- Ready outputs rise on the first `clk` edge after `aresetn` deasserts.
- Reset mid-operation: any held beats are discarded with no drain. Outputs return to reset values asynchronously.

## Timing
- Latency: a beat accepted at edge N is presented on the output after edge N, i.e. visible in cycle N+1. One cycle latency per direction.
- Throughput: one beat per cycle per channel when downstream ready is held high.
- Capacity: 2 beats per channel. Upstream sees ready drop one cycle after the downstream stall that fills the skid register.
- No combinational path from any input to any output. Every output is a flop Q.
- After FULL → ONE, in_ready is high in the following cycle. Sustained alternating stalls still give no bubble beyond the stalled cycles.

## Structure
- Package `axil_pkg` holds:
  - Response constants OKAY = 2'b00, EXOKAY, SLVERR, DECERR.
  - Payload typedefs `axil_aw_t` {addr, prot}, `axil_w_t` {data, strb}, `axil_b_t` {resp}, `axil_ar_t` {addr, prot}, `axil_r_t` {data, resp}, parameterised via package widths.
  - State enum `skid_state_e` {EMPTY, ONE, FULL}.
- Sub-module `axil_skid_buf #(W)`: generic valid/ready skid buffer over a W-bit payload. The top instantiates it five times, once per channel, three forward and two reverse.

## Test plan
- Reset:
  - Hold `aresetn` = 0 for 5 cycles → all valids/readies 0.
  - Release → all five readies = 1 after the first edge.
- Single write:
  - Stimulus: AW addr 0x10, W data 0xDEADBEEF strb 0xF at cycle 0; `m_awready` = `m_wready` = 1.
  - Response: `m_awvalid`/`m_wvalid` with identical payload in cycle 1.
  - Then drive `m_bresp` = OKAY → `s_bvalid` with resp 00 one cycle later.
- Streaming:
  - Stimulus: 8 back-to-back ARs 0x0..0x1C, `m_arready` = 1.
  - Response: 8 consecutive `m_arvalid` beats in order, starting cycle 1, no bubbles.
- Backpressure:
  - Stimulus: `m_arready` = 0; offer A0, A1, A2.
  - Response: A0 and A1 accepted; `s_arready` = 0 while A2 waits.
  - Raise `m_arready` → output order A0, A1, A2; A2 accepted the cycle after A0 drains.
- Random stress: random valid/ready on all channels for 10k cycles with a scoreboard → no loss/duplication/reordering, payload stable under stall, no AXI protocol-checker violations.
- Mid-operation reset: fill AW to FULL, assert `aresetn` → `m_awvalid` = 0 immediately; after release, no stale beat is emitted.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared widths, response codes, channel payload types and skid-buffer state
// for the AXI4-Lite register station.
package axil_pkg;

  localparam int unsigned AXIL_ADDR_W = 32;
  localparam int unsigned AXIL_DATA_W = 32;
  localparam int unsigned AXIL_STRB_W = AXIL_DATA_W / 8;
  localparam int unsigned PROT_W      = 3;
  localparam int unsigned RESP_W      = 2;

  localparam logic [RESP_W-1:0] OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] EXOKAY = 2'b01;
  localparam logic [RESP_W-1:0] SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] DECERR = 2'b11;

  typedef struct packed {
    logic [AXIL_ADDR_W-1:0] addr;
    logic [PROT_W-1:0]      prot;
  } axil_aw_t;

  typedef struct packed {
    logic [AXIL_DATA_W-1:0] data;
    logic [AXIL_STRB_W-1:0] strb;
  } axil_w_t;

  typedef struct packed {
    logic [RESP_W-1:0] resp;
  } axil_b_t;

  typedef struct packed {
    logic [AXIL_ADDR_W-1:0] addr;
    logic [PROT_W-1:0]      prot;
  } axil_ar_t;

  typedef struct packed {
    logic [AXIL_DATA_W-1:0] data;
    logic [RESP_W-1:0]      resp;
  } axil_r_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/axil_skid_buf.sv
// Two-entry valid/ready skid buffer: main register drives the output, skid
// register absorbs the beat in flight when the downstream stalls.
module axil_skid_buf
  import axil_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q;
  skid_state_e  next_state;
  logic         in_fire;
  logic         out_fire;
  logic         load_main;
  logic         main_from_skid;
  logic         load_skid;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= next_state;
      in_ready  <= (next_state != FULL);
      out_valid <= (next_state != EMPTY);
    end
  end

  always_comb begin
    next_state = state_q;
    unique case (state_q)
      EMPTY: if (in_fire) next_state = ONE;
      ONE: begin
        if (in_fire && !out_fire)      next_state = FULL;
        else if (!in_fire && out_fire) next_state = EMPTY;
      end
      FULL:    if (out_fire) next_state = ONE;
      default: next_state = EMPTY;
    endcase
  end

  // Datapath load enables; FULL never sees in_fire because in_ready is low.
  always_comb begin
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      EMPTY: load_main = in_fire;
      ONE: begin
        load_main = in_fire & out_fire;
        load_skid = in_fire & ~out_fire;
      end
      FULL: begin
        load_main      = out_fire;
        main_from_skid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
  end

  assign out_data = main_q;

endmodule

// File: rtl/axil_reg_station.sv
// AXI4-Lite register slice: one independent skid buffer per channel so that
// every output, including ready, comes straight from a flop.
module axil_reg_station
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                s_awvalid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [2:0]          s_awprot,
  output logic                s_awready,
  input  logic                s_wvalid,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wready,
  output logic                s_bvalid,
  output logic [1:0]          s_bresp,
  input  logic                s_bready,
  input  logic                s_arvalid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [2:0]          s_arprot,
  output logic                s_arready,
  output logic                s_rvalid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  input  logic                s_rready,
  output logic                m_awvalid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [2:0]          m_awprot,
  input  logic                m_awready,
  output logic                m_wvalid,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_wready,
  input  logic                m_bvalid,
  input  logic [1:0]          m_bresp,
  output logic                m_bready,
  output logic                m_arvalid,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [2:0]          m_arprot,
  input  logic                m_arready,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  output logic                m_rready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned AW_W   = ADDR_W + PROT_W;
  localparam int unsigned W_W    = DATA_W + STRB_W;
  localparam int unsigned B_W    = RESP_W;
  localparam int unsigned R_W    = DATA_W + RESP_W;

  logic [AW_W-1:0] aw_out;
  logic [W_W-1:0]  w_out;
  logic [B_W-1:0]  b_out;
  logic [AW_W-1:0] ar_out;
  logic [R_W-1:0]  r_out;

  // Forward channels: s_ -> m_
  axil_skid_buf #(.W(AW_W)) u_aw (
    .clk       (clk),
    .aresetn   (aresetn),
    .in_valid  (s_awvalid),
    .in_ready  (s_awready),
    .in_data   ({s_awaddr, s_awprot}),
    .out_valid (m_awvalid),
    .out_ready (m_awready),
    .out_data  (aw_out)
  );

  axil_skid_buf #(.W(W_W)) u_w (
    .clk       (clk),
    .aresetn   (aresetn),
    .in_valid  (s_wvalid),
    .in_ready  (s_wready),
    .in_data   ({s_wdata, s_wstrb}),
    .out_valid (m_wvalid),
    .out_ready (m_wready),
    .out_data  (w_out)
  );

  axil_skid_buf #(.W(AW_W)) u_ar (
    .clk       (clk),
    .aresetn   (aresetn),
    .in_valid  (s_arvalid),
    .in_ready  (s_arready),
    .in_data   ({s_araddr, s_arprot}),
    .out_valid (m_arvalid),
    .out_ready (m_arready),
    .out_data  (ar_out)
  );

  // Reverse channels: m_ -> s_
  axil_skid_buf #(.W(B_W)) u_b (
    .clk       (clk),
    .aresetn   (aresetn),
    .in_valid  (m_bvalid),
    .in_ready  (m_bready),
    .in_data   (m_bresp),
    .out_valid (s_bvalid),
    .out_ready (s_bready),
    .out_data  (b_out)
  );

  axil_skid_buf #(.W(R_W)) u_r (
    .clk       (clk),
    .aresetn   (aresetn),
    .in_valid  (m_rvalid),
    .in_ready  (m_rready),
    .in_data   ({m_rdata, m_rresp}),
    .out_valid (s_rvalid),
    .out_ready (s_rready),
    .out_data  (r_out)
  );

  assign {m_awaddr, m_awprot} = aw_out;
  assign {m_wdata, m_wstrb}   = w_out;
  assign s_bresp              = b_out;
  assign {m_araddr, m_arprot} = ar_out;
  assign {s_rdata, s_rresp}   = r_out;

endmodule

// File: tb/tb_axil_reg_station.sv
// Directed and table-driven self-checking bench for axil_reg_station.
module tb_axil_reg_station;
  import axil_pkg::*;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [2:0]  s_awprot, s_arprot;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;

  int n_chk  = 0;
  int n_fail = 0;

  axil_reg_station #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .aresetn(aresetn),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ar_valid;
    logic [31:0] ar_addr;
    logic        mready;
    logic        exp_sready;
    logic        exp_mvalid;
    logic [31:0] exp_maddr;
  } ar_vec_t;

  ar_vec_t     vecs[$];
  logic [31:0] sb[$];
  logic [31:0] wcnt;
  logic [31:0] held_data;
  logic        held;
  int          guard;

  initial begin
    aresetn   = 1'b0;
    s_awvalid = 1'b0; s_awaddr = '0; s_awprot = '0;
    s_wvalid  = 1'b0; s_wdata  = '0; s_wstrb  = '0;
    s_bready  = 1'b0;
    s_arvalid = 1'b0; s_araddr = '0; s_arprot = '0;
    s_rready  = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0;
    m_bvalid  = 1'b0; m_bresp  = '0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0; m_rdata  = '0; m_rresp = '0;

    // Reset: everything quiet for 5 cycles, readies rise one edge after release.
    repeat (5) tick();
    chk("rst_valids", 64'({m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid}), 64'd0);
    chk("rst_readies", 64'({s_awready, s_wready, s_arready, m_bready, m_rready}), 64'd0);
    chk("rst_payload", 64'(m_awaddr | m_wdata | m_araddr | s_rdata), 64'd0);
    aresetn = 1'b1;
    #1;
    chk("readies_before_edge", 64'({s_awready, s_wready, s_arready, m_bready, m_rready}), 64'd0);
    tick();
    chk("readies_after_edge", 64'({s_awready, s_wready, s_arready, m_bready, m_rready}), 64'h1f);

    // Single write with B response.
    s_awvalid = 1'b1; s_awaddr = 32'h10; s_awprot = 3'b001;
    s_wvalid  = 1'b1; s_wdata  = 32'hDEADBEEF; s_wstrb = 4'hF;
    m_awready = 1'b1; m_wready = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("wr_awvalid", 64'(m_awvalid), 64'd1);
    chk("wr_awaddr", 64'(m_awaddr), 64'h10);
    chk("wr_awprot", 64'(m_awprot), 64'h1);
    chk("wr_wvalid", 64'(m_wvalid), 64'd1);
    chk("wr_wdata", 64'(m_wdata), 64'hDEADBEEF);
    chk("wr_wstrb", 64'(m_wstrb), 64'hF);
    tick();
    chk("wr_drained", 64'({m_awvalid, m_wvalid}), 64'd0);
    m_bvalid = 1'b1; m_bresp = OKAY; s_bready = 1'b1;
    tick();
    m_bvalid = 1'b0; m_bresp = DECERR;
    chk("b_valid", 64'(s_bvalid), 64'd1);
    chk("b_resp", 64'(s_bresp), 64'(OKAY));
    tick();
    chk("b_drained", 64'(s_bvalid), 64'd0);

    // Read response stalled upstream: must stay stable until accepted.
    m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D; m_rresp = SLVERR; s_rready = 1'b0;
    tick();
    m_rvalid = 1'b0; m_rdata = 32'h0;
    chk("r_valid", 64'(s_rvalid), 64'd1);
    chk("r_data", 64'({s_rdata, s_rresp}), 64'({32'hCAFEF00D, SLVERR}));
    tick();
    chk("r_stall_valid", 64'(s_rvalid), 64'd1);
    chk("r_stall_data", 64'({s_rdata, s_rresp}), 64'({32'hCAFEF00D, SLVERR}));
    s_rready = 1'b1;
    tick();
    chk("r_drained", 64'(s_rvalid), 64'd0);

    // AR table: backpressure A0/A1/A2 then an 8-beat stream.
    vecs.push_back('{1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h100});
    vecs.push_back('{1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 32'h100});
    vecs.push_back('{1'b1, 32'h108, 1'b0, 1'b0, 1'b1, 32'h100});
    vecs.push_back('{1'b1, 32'h108, 1'b1, 1'b1, 1'b1, 32'h104});
    vecs.push_back('{1'b1, 32'h108, 1'b1, 1'b1, 1'b1, 32'h108});
    vecs.push_back('{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h108});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1'b1, 32'(i * 4), 1'b1, 1'b1, 1'b1, 32'(i * 4)});
    vecs.push_back('{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h1C});
    s_arprot = 3'b010;
    for (int i = 0; i < vecs.size(); i++) begin
      s_arvalid = vecs[i].ar_valid;
      s_araddr  = vecs[i].ar_addr;
      m_arready = vecs[i].mready;
      tick();
      chk($sformatf("ar%0d_sready", i), 64'(s_arready), 64'(vecs[i].exp_sready));
      chk($sformatf("ar%0d_mvalid", i), 64'(m_arvalid), 64'(vecs[i].exp_mvalid));
      chk($sformatf("ar%0d_maddr", i), 64'(m_araddr), 64'(vecs[i].exp_maddr));
    end
    chk("ar_prot", 64'(m_arprot), 64'h2);
    s_arvalid = 1'b0;

    // Random W stress with scoreboard and stall-stability check.
    wcnt = 32'h1000;
    held = 1'b0;
    held_data = '0;
    for (int c = 0; c < 2000; c++) begin
      if (held) begin
        chk("w_stall_valid", 64'(m_wvalid), 64'd1);
        chk("w_stall_data", 64'(m_wdata), 64'(held_data));
      end
      s_wvalid = 1'($urandom_range(0, 1));
      s_wdata  = wcnt;
      s_wstrb  = wcnt[3:0];
      m_wready = 1'($urandom_range(0, 2) != 0);
      if (m_wvalid && m_wready) begin
        if (sb.size() == 0) chk("w_spurious", 64'd1, 64'd0);
        else chk("w_order", 64'({m_wdata, m_wstrb}), 64'({sb[0], sb[0][3:0]}));
        if (sb.size() != 0) void'(sb.pop_front());
      end
      held = m_wvalid && !m_wready;
      held_data = m_wdata;
      if (s_wvalid && s_wready) begin
        sb.push_back(wcnt);
        wcnt = wcnt + 32'd1;
      end
      tick();
    end
    s_wvalid = 1'b0;
    m_wready = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 10) begin
      if (m_wvalid) begin
        chk("w_drain_order", 64'(m_wdata), 64'(sb[0]));
        void'(sb.pop_front());
      end
      tick();
      guard++;
    end
    chk("w_scoreboard_empty", 64'(sb.size()), 64'd0);
    tick();
    chk("w_idle", 64'(m_wvalid), 64'd0);

    // Mid-operation reset with AW full.
    m_awready = 1'b0;
    s_awvalid = 1'b1; s_awaddr = 32'h20;
    tick();
    s_awaddr = 32'h24;
    tick();
    s_awvalid = 1'b0;
    chk("aw_full_sready", 64'(s_awready), 64'd0);
    chk("aw_full_mvalid", 64'(m_awvalid), 64'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("aw_rst_mvalid", 64'(m_awvalid), 64'd0);
    chk("aw_rst_sready", 64'(s_awready), 64'd0);
    chk("aw_rst_addr", 64'(m_awaddr), 64'd0);
    tick();
    aresetn = 1'b1;
    m_awready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("aw_no_stale", 64'(m_awvalid), 64'd0);
    end
    chk("aw_ready_back", 64'(s_awready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
